// File: rtl/boot_loader_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boot_loader_stream : sync handshake, size/program/checksum reception and
//                      ready/valid word output for the UART boot path.
// Revision 1.0
// ----------------------------------------------------------------------------
module boot_loader_stream #(
    parameter int         WORD_BYTES    = 4,
    parameter int         INTERVAL_SYNC = 100,
    parameter logic [7:0] SYNC_BYTE     = 8'h99,
    parameter logic [7:0] ACK_BYTE      = 8'haa,
    parameter logic [7:0] NAK_BYTE      = 8'h55,
    parameter int         CHECKSUM_EN   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rx_ready_i,
    input  logic [7:0]              rdata_i,
    input  logic                    tx_busy_i,
    output logic                    tx_start_o,
    output logic [7:0]              sdata_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [8*WORD_BYTES-1:0] out_word_o,
    output logic                    out_is_instr_o,
    output logic                    restart_o,
    output logic                    program_loaded_o,
    output logic                    overflow_o,
    output logic                    csum_err_o
);

    localparam int                W_BITS     = 8 * WORD_BYTES;
    localparam int                LANE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX   = LANE_W'(WORD_BYTES - 1);
    localparam logic [15:0]       SYNC_LIMIT = 16'(INTERVAL_SYNC);

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_SIZE = 3'd1,
        S_PROG = 3'd2,
        S_CSUM = 3'd3,
        S_RESP = 3'd4,
        S_DATA = 3'd5
    } state_e;

    state_e              state_q,     state_d;
    logic [15:0]         sync_cnt_q,  sync_cnt_d;
    logic [31:0]         size_q,      size_d;
    logic [1:0]          size_idx_q,  size_idx_d;
    logic [31:0]         rcv_q,       rcv_d;
    logic [7:0]          csum_q,      csum_d;
    logic [LANE_W-1:0]   lane_q,      lane_d;
    logic [W_BITS-1:0]   buf_q,       buf_d;
    logic                nak_q,       nak_d;
    logic                tx_start_q,  tx_start_d;
    logic [7:0]          sdata_q,     sdata_d;
    logic                restart_q,   restart_d;
    logic                out_valid_q, out_valid_d;
    logic [W_BITS-1:0]   out_word_q,  out_word_d;
    logic                out_instr_q, out_instr_d;
    logic                overflow_q,  overflow_d;
    logic                csum_err_q,  csum_err_d;

    logic [W_BITS-1:0]   word_w;
    logic [31:0]         size_full_w;
    logic                emit_w;
    logic                emit_instr_w;
    logic                resp_go_w;
    logic                resp_nak_w;
    logic                nak_w;
    logic                last_w;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        size_d       = size_q;
        size_idx_d   = size_idx_q;
        rcv_d        = rcv_q;
        csum_d       = csum_q;
        lane_d       = lane_q;
        buf_d        = buf_q;
        nak_d        = nak_q;
        tx_start_d   = 1'b0;
        sdata_d      = sdata_q;
        restart_d    = 1'b0;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_instr_d  = out_instr_q;
        overflow_d   = overflow_q;
        csum_err_d   = csum_err_q;
        emit_w       = 1'b0;
        emit_instr_w = 1'b0;
        resp_go_w    = 1'b0;
        resp_nak_w   = 1'b0;
        nak_w        = 1'b0;
        last_w       = 1'b0;
        size_full_w  = {rdata_i, size_q[31:8]};

        // Current buffer with the incoming byte dropped into the active lane.
        word_w = buf_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                word_w[i*8 +: 8] = rdata_i;
            end
        end

        case (state_q)
            S_SYNC: begin
                if (rx_ready_i) begin
                    state_d    = S_SIZE;
                    size_idx_d = 2'd0;
                end else if (sync_cnt_q >= SYNC_LIMIT && !tx_busy_i && !tx_start_q) begin
                    tx_start_d = 1'b1;
                    sdata_d    = SYNC_BYTE;
                    sync_cnt_d = 16'd0;
                end else if (sync_cnt_q < SYNC_LIMIT) begin
                    sync_cnt_d = sync_cnt_q + 16'd1;
                end
            end
            S_SIZE: begin
                if (rx_ready_i) begin
                    size_d     = size_full_w;
                    size_idx_d = size_idx_q + 2'd1;
                    if (size_idx_q == 2'd3) begin
                        rcv_d  = 32'd0;
                        csum_d = 8'd0;
                        nak_d  = 1'b0;
                        if (size_full_w != 32'd0) begin
                            state_d = S_PROG;
                            lane_d  = '0;
                            buf_d   = '0;
                        end else begin
                            state_d = (CHECKSUM_EN != 0) ? S_CSUM : S_RESP;
                        end
                    end
                end
            end
            S_PROG: begin
                if (rx_ready_i) begin
                    csum_d = csum_q + rdata_i;
                    rcv_d  = rcv_q + 32'd1;
                    last_w = (rcv_q + 32'd1 == size_q);
                    if (last_w || lane_q == LANE_MAX) begin
                        emit_w       = 1'b1;
                        emit_instr_w = 1'b1;
                        lane_d       = '0;
                        buf_d        = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        buf_d  = word_w;
                    end
                    if (last_w) begin
                        state_d = (CHECKSUM_EN != 0) ? S_CSUM : S_RESP;
                    end
                end
            end
            S_CSUM: begin
                if (rx_ready_i) begin
                    nak_w      = (rdata_i != csum_q);
                    nak_d      = nak_w;
                    csum_err_d = csum_err_q | nak_w;
                    // Respond in the very next cycle when the sender is free.
                    if (!tx_busy_i && !tx_start_q) begin
                        resp_go_w  = 1'b1;
                        resp_nak_w = nak_w;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (!tx_busy_i && !tx_start_q) begin
                    resp_go_w  = 1'b1;
                    resp_nak_w = nak_q;
                end
            end
            S_DATA: begin
                if (rx_ready_i) begin
                    if (lane_q == LANE_MAX) begin
                        emit_w = 1'b1;
                        lane_d = '0;
                        buf_d  = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        buf_d  = word_w;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (resp_go_w) begin
            tx_start_d = 1'b1;
            sdata_d    = resp_nak_w ? NAK_BYTE : ACK_BYTE;
            if (resp_nak_w) begin
                restart_d  = 1'b1;
                state_d    = S_SIZE;
                size_idx_d = 2'd0;
            end else begin
                state_d = S_DATA;
                lane_d  = '0;
                buf_d   = '0;
            end
        end

        // A held, unaccepted word wins over a newly completed one.
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (emit_w) begin
            if (out_valid_q && !out_ready_i) begin
                overflow_d = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_word_d  = word_w;
                out_instr_d = emit_instr_w;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_SYNC;
            sync_cnt_q  <= 16'd0;
            size_q      <= 32'd0;
            size_idx_q  <= 2'd0;
            rcv_q       <= 32'd0;
            csum_q      <= 8'd0;
            lane_q      <= '0;
            buf_q       <= '0;
            nak_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            sdata_q     <= 8'h00;
            restart_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_instr_q <= 1'b0;
            overflow_q  <= 1'b0;
            csum_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            size_q      <= size_d;
            size_idx_q  <= size_idx_d;
            rcv_q       <= rcv_d;
            csum_q      <= csum_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            nak_q       <= nak_d;
            tx_start_q  <= tx_start_d;
            sdata_q     <= sdata_d;
            restart_q   <= restart_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_instr_q <= out_instr_d;
            overflow_q  <= overflow_d;
            csum_err_q  <= csum_err_d;
        end
    end

    assign tx_start_o       = tx_start_q;
    assign sdata_o          = sdata_q;
    assign restart_o        = restart_q;
    assign out_valid_o      = out_valid_q;
    assign out_word_o       = out_word_q;
    assign out_is_instr_o   = out_instr_q;
    assign overflow_o       = overflow_q;
    assign csum_err_o       = csum_err_q;
    assign program_loaded_o = (state_q == S_DATA);

endmodule
`default_nettype wire

// File: doc/boot_loader_stream.md
Name: boot_loader_stream

Overview:
- Parametrised successor to the UART boot loader; sits between the UART receiver/sender and the instruction/data memory loaders.
- Performs the sync handshake, then reads a byte-count program size, then streams program words.
- Adds over the previous generation: configurable word width, ready/valid output with overflow detection, zero-padded partial final instruction word, optional 8-bit checksum with ACK/NAK retry, 16-bit sync interval.

Parameters:
- WORD_BYTES, 4: bytes per output word; legal range 1..8.
- INTERVAL_SYNC, 100: cycles between repeated SYNC_BYTE transmissions; legal range 1..65535.
- SYNC_BYTE, 8'h99: byte sent repeatedly while waiting for the host.
- ACK_BYTE, 8'haa: byte sent on successful program receipt.
- NAK_BYTE, 8'h55: byte sent on checksum mismatch.
- CHECKSUM_EN, 1: 1 means a checksum byte follows the program; 0 means no checksum phase.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_ready  in  1  one-cycle strobe: rdata is valid
- rdata  in  8  received byte
- tx_busy  in  1  UART sender busy
- tx_start  out  1  one-cycle strobe: send sdata
- sdata  out  8  byte to send; held stable until the next tx_start
- out_valid  out  1  out_word holds a word not yet accepted
- out_ready  in  1  consumer accepts the word
- out_word  out  8*WORD_BYTES  assembled word, little-endian (first byte in bits [7:0])
- out_is_instr  out  1  1 = instruction word, 0 = data word; qualified by out_valid
- restart  out  1  one-cycle strobe on NAK: discard all instruction words already received
- program_loaded  out  1  high in DATA state
- overflow  out  1  sticky: a word was dropped because of backpressure
- csum_err  out  1  sticky: at least one checksum mismatch has occurred

Behaviour:
- Reset (async, reset low):
  - State = SYNC.
  - All outputs 0; sdata = 8'h00.
  - Counters, checksum and byte buffer cleared.
  - Reset asserted mid-transfer aborts immediately; no word is emitted.
- States: SYNC, SIZE, PROG, CSUM, RESP, DATA.
- SYNC:
  - Counter increments every cycle, saturating at INTERVAL_SYNC.
  - When counter >= INTERVAL_SYNC and !tx_busy and !tx_start: pulse tx_start with sdata = SYNC_BYTE; counter = 0.
  - Any rx_ready: byte discarded, go to SIZE. This has priority over a same-cycle send: no tx_start in that cycle.
- SIZE:
  - Collect 4 bytes, little-endian, into size (unit: bytes).
  - On the 4th byte: clear received count and checksum.
  - Then go to PROG if size != 0; otherwise go to CSUM (CHECKSUM_EN=1) or RESP.
- PROG:
  - Each byte: checksum += byte (mod 256); received count += 1; byte placed at the current lane of the word buffer.
  - A word is emitted (out_is_instr = 1) when WORD_BYTES bytes are collected, or when the last program byte arrives; a partial final word has its unused upper lanes set to 0.
  - After the last byte: go to CSUM or RESP.
- CSUM:
  - Next byte compared with the checksum.
  - Match: send ACK_BYTE.
  - Mismatch: send NAK_BYTE; set csum_err.
  - Go to RESP.
- RESP:
  - Wait for !tx_busy, then pulse tx_start once.
  - After ACK: go to DATA.
  - After NAK: pulse restart in the same cycle and go to SIZE. The host resends size and program.
  - With CHECKSUM_EN=0, RESP always sends ACK.
  - Bytes received in RESP are ignored.
- DATA:
  - program_loaded = 1.
  - Bytes are assembled into words and emitted with out_is_instr = 0, on full words only; trailing partial bytes are never emitted.
  - DATA is terminal until reset.
- Output handshake:
  - out_valid rises the cycle after the completing byte and holds until out_valid && out_ready.
  - If a word completes while out_valid && !out_ready: the new word is dropped, the held word is kept, overflow is set.
  - If a word completes in the same cycle as acceptance: the new word loads and out_valid stays 1, with no bubble.
- Lane index and byte buffer reset to lane 0 at entry to PROG and at entry to DATA.
- Latencies:
  - rx_ready to out_valid: 1 cycle.
  - Checksum byte to tx_start: >= 1 cycle, and 1 cycle when tx_busy is low.

Test Plan:
- Sync: INTERVAL_SYNC=4, no rx, tx_busy=0 -> tx_start with sdata=8'h99 every 5 cycles. Then rx byte 8'h00 -> no further 8'h99; state is SIZE.
- Program with checksum: size bytes 08 00 00 00; program 01 02 03 04 05 06 07 08; checksum 8'h24; out_ready=1 -> words 32'h04030201 and 32'h08070605 with out_is_instr=1; then tx_start with 8'haa; program_loaded=1.
- Partial word: size 5; program 11 22 33 44 55; checksum 8'hff -> words 32'h44332211 and 32'h00000055.
- NAK retry: 4-byte program AA BB CC DD with wrong checksum 8'h00 -> sdata=8'h55, restart pulse, csum_err=1. Resend with checksum 8'h0e -> 8'haa, program_loaded=1.
- Backpressure in DATA: out_ready=0, send 8 bytes -> first word held, second dropped, overflow=1. Then out_ready=1 -> first word accepted, out_valid falls.
- Async reset: reset low mid-PROG, asynchronously with respect to clock -> outputs 0 immediately. After reset is released, the block resumes sending 8'h99.
